// File: rtl/servo_pkg.sv
// Shared servo-domain constants: FSM encoding, error codes and tick limits.
// The tick limits are shared with servo_rpm_ctrl.
package servo_pkg;

    localparam int DEF_CNT_W      = 9;
    localparam int DEF_MIN_HIGH   = 5;
    localparam int DEF_MAX_HIGH   = 25;
    localparam int DEF_MIN_PERIOD = 150;
    localparam int DEF_MAX_PERIOD = 250;
    localparam int DEF_LOCK_COUNT = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_SHORT  = 2'b01;
    localparam logic [1:0] ERR_LONG   = 2'b10;
    localparam logic [1:0] ERR_PERIOD = 2'b11;

endpackage

// File: rtl/servo_pwm_decoder_sync_edge.sv
// Two-flop synchronizer plus delay flop with rise/fall detection.
// All flops reset to RST_VAL so a static line never reads as an edge.
module sync_edge
    import servo_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic lvl_q, lvl_d;
    logic dly_q, dly_d;

    always_comb begin
        meta_d = din;
        lvl_d  = meta_q;
        dly_d  = lvl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            lvl_q  <= RST_VAL;
            dly_q  <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            lvl_q  <= lvl_d;
            dly_q  <= dly_d;
        end
    end

    assign level = lvl_q;
    assign rise  = lvl_q & ~dly_q;
    assign fall  = ~lvl_q & dly_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures high time and rise-to-rise period per frame,
// flags malformed frames, and tracks lock and loss of signal.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MIN_HIGH   = DEF_MIN_HIGH,
    parameter int MAX_HIGH   = DEF_MAX_HIGH,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int MAX_PERIOD = DEF_MAX_PERIOD,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] pulse_width,
    output logic [CNT_W-1:0] period,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic             locked,
    output logic             signal_lost
);

    localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  HI_MIN   = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0]  HI_LONG  = CNT_W'(MAX_HIGH + 1);
    localparam logic [CNT_W-1:0]  PER_MIN  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  PER_TOUT = CNT_W'(MAX_PERIOD + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_COUNT);

    logic s_lvl, s_rise, s_fall;

    sync_edge #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pwm_in),
        .level(s_lvl),
        .rise (s_rise),
        .fall (s_fall)
    );

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [CNT_W-1:0]  pulse_width_q, pulse_width_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              frame_valid_q, frame_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic              signal_lost_q, signal_lost_d;
    logic [CNT_W-1:0]  hi_inc, per_inc;

    assign hi_inc  = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + CNT_ONE;
    assign per_inc = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;

    always_comb begin
        state_d       = state_q;
        high_cnt_d    = high_cnt_q;
        per_cnt_d     = per_cnt_q;
        width_d       = width_q;
        pulse_width_d = pulse_width_q;
        period_d      = period_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        signal_lost_d = signal_lost_q;
        lock_cnt_d    = lock_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (s_rise) begin
                    high_cnt_d = CNT_ONE;
                    per_cnt_d  = CNT_ONE;
                    state_d    = ST_HIGH;
                end
            end
            ST_HIGH: begin
                per_cnt_d = per_inc;
                if (s_fall) begin
                    if (high_cnt_q < HI_MIN) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_SHORT;
                        state_d     = ST_IDLE;
                    end else begin
                        width_d = high_cnt_q;
                        state_d = ST_LOW;
                    end
                end else begin
                    high_cnt_d = hi_inc;
                    if (hi_inc == HI_LONG) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LONG;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_LOW: begin
                // In LOW the previous sample was low, so level marks the rise.
                if (s_lvl) begin
                    high_cnt_d = CNT_ONE;
                    per_cnt_d  = CNT_ONE;
                    state_d    = ST_HIGH;
                    if (per_cnt_q < PER_MIN) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_PERIOD;
                    end else begin
                        frame_valid_d = 1'b1;
                        pulse_width_d = width_q;
                        period_d      = per_cnt_q;
                        signal_lost_d = 1'b0;
                    end
                end else begin
                    per_cnt_d = per_inc;
                    if (per_inc == PER_TOUT) begin
                        frame_err_d   = 1'b1;
                        err_code_d    = ERR_PERIOD;
                        signal_lost_d = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_err_d) begin
            lock_cnt_d = '0;
        end else if (frame_valid_d && lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
        locked_d = (lock_cnt_d == LOCK_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            high_cnt_q    <= '0;
            per_cnt_q     <= '0;
            width_q       <= '0;
            pulse_width_q <= '0;
            period_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            lock_cnt_q    <= '0;
            locked_q      <= 1'b0;
            signal_lost_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            high_cnt_q    <= high_cnt_d;
            per_cnt_q     <= per_cnt_d;
            width_q       <= width_d;
            pulse_width_q <= pulse_width_d;
            period_q      <= period_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            lock_cnt_q    <= lock_cnt_d;
            locked_q      <= locked_d;
            signal_lost_q <= signal_lost_d;
        end
    end

    assign pulse_width = pulse_width_q;
    assign period      = period_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign locked      = locked_q;
    assign signal_lost = signal_lost_q;

endmodule

// File: doc/servo_pwm_decoder.md
# servo_pwm_decoder

Receive-side counterpart of the servo PWM generator. It samples a servo control waveform (the looped-back `servo_pwm` line or an external RC receiver channel) and measures the high time and frame period of every pulse in clock ticks. It publishes each validated frame with a one-cycle strobe, classifies malformed frames, and tracks lock and loss of signal. It runs in the 10 kHz domain alongside the servo and gauge logic, so it can self-check the gauge output.

## Interface
- `CNT_W`, 9: width of the width and period counters and outputs.
- `MIN_HIGH`, 5: shortest legal high time in ticks (0.5 ms at 10 kHz).
- `MAX_HIGH`, 25: longest legal high time in ticks.
- `MIN_PERIOD`, 150: shortest legal rise-to-rise period in ticks.
- `MAX_PERIOD`, 250: longest legal period in ticks; exceeding it is a timeout.
- `LOCK_COUNT`, 3: consecutive valid frames required to assert `locked`.

- `clk`  in  1  sample clock (10 kHz in the system).
- `rst_n`  in  1  asynchronous, active-low reset.
- `pwm_in`  in  1  asynchronous servo PWM input.
- `pulse_width`  out  CNT_W  high time of the last valid frame.
- `period`  out  CNT_W  rise-to-rise period of the last valid frame.
- `frame_valid`  out  1  one-cycle strobe; `pulse_width` and `period` updated.
- `frame_err`  out  1  one-cycle strobe on any malformed frame.
- `err_code`  out  2  last error, held until the next error: 01 high too short, 10 high too long, 11 period out of range.
- `locked`  out  1  LOCK_COUNT consecutive valid frames with no intervening error.
- `signal_lost`  out  1  period timeout occurred; cleared by the next `frame_valid`.

## Operation
- Input path is a 2-flop synchronizer to `s`, plus a delay flop to `s_d`. All three flops reset to 1, so a line held high through reset is never taken as a rising edge.
- Edges: `rise = s & ~s_d`, `fall = ~s & s_d`.
- FSM states are IDLE, HIGH and LOW. Reset state is IDLE.
- **IDLE:**
  - On `rise`, load `high_cnt` = 1 and `per_cnt` = 1, then go to HIGH.
- **HIGH:** `high_cnt` and `per_cnt` increment each cycle.
  - If `high_cnt` reaches MAX_HIGH+1: error 10, go to IDLE.
  - On `fall` with `high_cnt` < MIN_HIGH: error 01, go to IDLE.
  - On `fall` otherwise: latch the width internally and go to LOW.
- **LOW:** `per_cnt` increments each cycle.
  - If `per_cnt` reaches MAX_PERIOD+1: error 11, set `signal_lost`, go to IDLE.
  - On `rise` with `per_cnt` < MIN_PERIOD: error 11, restart counters at 1, go to HIGH. The new frame is still measured.
  - On `rise` otherwise: publish the latched width and `per_cnt`, pulse `frame_valid`, clear `signal_lost`, restart counters at 1, go to HIGH.
- Counters saturate at all-ones and never wrap. Parameters must satisfy MAX_PERIOD < 2^CNT_W − 1.
- Lock tracking:
  - A counter increments on each `frame_valid` and saturates at LOCK_COUNT; `locked` = (count == LOCK_COUNT).
  - Any `frame_err` clears the counter and deasserts `locked` in the same cycle as the strobe.
- `frame_valid` and `frame_err` are never asserted together.

## Timing
- Reset values:
  - `pulse_width`, `period`, `err_code` = 0.
  - `frame_valid`, `frame_err`, `locked`, `signal_lost` = 0.
- All outputs are registered.
- Latency: a pin edge is visible as `rise`/`fall` 2 cycles after its first sampling clock. Strobes and data assert on the following clock edge, 3 cycles after first sampling.
- Measurement resolution is one tick. A pulse sampled high on N clocks yields `pulse_width` = N.
- Reset asserted mid-frame aborts the measurement with no strobe. The first frame after release is discarded (IDLE needs a genuine low then `rise`), and measurement starts on the next rising edge.

## Structure
- Shared package `servo_pkg`:
  - state encoding (IDLE/HIGH/LOW).
  - `err_code` constants (ERR_SHORT=2'b01, ERR_LONG=2'b10, ERR_PERIOD=2'b11).
  - default tick limits, shared with `servo_rpm_ctrl`.
- One sub-module, `sync_edge`:
  - 2-flop synchronizer plus delay flop.
  - reset value parameterised (1 here).
  - outputs `level`, `rise`, `fall`.

## Test plan
- Frames of 15-tick high / 200-tick period: each `frame_valid` reports `pulse_width`=15, `period`=200. `locked` rises with the third strobe.
- After lock, one frame with a 3-tick high: `frame_err`, `err_code`=01, `locked`=0. The next two valid frames keep `locked`=0 and the third restores it.
- `pwm_in` held high for 40 ticks: `frame_err` with `err_code`=10 when `high_cnt` reaches 26. No `frame_valid` until a full legal frame follows.
- After a valid frame, `pwm_in` stuck low: `frame_err`, `err_code`=11 and `signal_lost`=1 when `per_cnt` reaches 251. A later 15/200 frame pair clears `signal_lost` with `frame_valid`.
- Second rise 100 ticks after the first: `err_code`=11 strobe at that rise. The next frame measured from that rise is reported correctly (e.g. 20/200).
- `pwm_in` high during reset and `rst_n` released mid-pulse: no strobe for the truncated pulse. The first `frame_valid` corresponds to the second complete rising edge.
